twiddle_addr_gen: RTL

TWIDDLE_ADDR_GEN -- requirements
Module: twiddle_addr_gen

---
 rtl/twiddle_addr_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/twiddle_addr_gen.sv
//==============================================================================
// Module      : twiddle_addr_gen
// Description : Twiddle-factor ROM address generator for a multi-stage
//               radix-16 FFT. For every butterfly group j of every stage it
//               emits the exponent k = (j << RADIX_W*stage) mod 2^(3*RADIX_W),
//               split into three RADIX_W-bit ROM digit addresses. Each address
//               is held for one 4-cycle slot that matches the downstream
//               4-phase ROM bank schedule.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module twiddle_addr_gen #(
  parameter int RADIX_W   = 4,     // width of one ROM digit address
  parameter int NUM_STAGE = 4,     // radix-16 stages per transform (>= 2)
  parameter int J_MAX     = 4095   // last butterfly-group index per stage (>= 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         hold,
  output logic                         busy,
  output logic                         ROM_CEN,
  output logic [RADIX_W-1:0]           MA0,
  output logic [RADIX_W-1:0]           MA1,
  output logic [RADIX_W-1:0]           MA2,
  output logic                         ma_valid,
  output logic [$clog2(NUM_STAGE)-1:0] stage_idx,
  output logic                         done
);

  // Counter and exponent widths
  localparam int c_jw = $clog2(J_MAX + 1);
  localparam int c_sw = $clog2(NUM_STAGE);
  localparam int c_kw = 3 * RADIX_W;

  localparam logic [c_jw-1:0] c_j_last     = c_jw'(J_MAX);
  localparam logic [c_jw-1:0] c_j_one      = c_jw'(1);
  localparam logic [c_sw-1:0] c_stage_last = c_sw'(NUM_STAGE - 1);
  localparam logic [c_sw-1:0] c_stage_one  = c_sw'(1);
  localparam logic [1:0]      c_slot_last  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_slot;
  logic [1:0]      w_slot_nxt;
  logic [c_jw-1:0] r_j;
  logic [c_jw-1:0] w_j_nxt;
  logic [c_sw-1:0] r_stage;
  logic [c_sw-1:0] w_stage_nxt;

  // Exponent of the address that will be presented next cycle
  logic [31:0]     w_shamt;
  logic [c_kw-1:0] w_k;
  logic            w_run_nxt;

  // Registered outputs
  logic            r_busy;
  logic            r_rom_cen;
  logic [c_kw-1:0] r_ma;
  logic            r_ma_valid;
  logic [c_sw-1:0] r_stage_idx;
  logic            r_done;

  // State and counter registers; counters only move in RUN when not held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_slot  <= 2'd0;
      r_j     <= '0;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_j     <= w_j_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  // Next-state and counter advance: slot -> j -> stage ripple, exit after last slot
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_j_nxt     = r_j;
    w_stage_nxt = r_stage;
    case (r_state)
      S_IDLE: begin
        // Counters restart from zero for every transform; start wins over hold
        w_slot_nxt  = 2'd0;
        w_j_nxt     = '0;
        w_stage_nxt = '0;
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!hold) begin
          if (r_slot == c_slot_last) begin
            w_slot_nxt = 2'd0;
            if (r_j == c_j_last) begin
              w_j_nxt = '0;
              if (r_stage == c_stage_last) begin
                w_stage_nxt = '0;
                w_state_nxt = S_DONE;
              end else begin
                w_stage_nxt = r_stage + c_stage_one;
              end
            end else begin
              w_j_nxt = r_j + c_j_one;
            end
          end else begin
            w_slot_nxt = r_slot + 2'd1;
          end
        end
      end
      S_DONE: begin
        // Single-cycle epilogue; start is not looked at here
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_slot_nxt  = 2'd0;
        w_j_nxt     = '0;
        w_stage_nxt = '0;
      end
    endcase
  end

  // k = j * 16^stage truncated to three digits; bits of j shifted past the
  // top are dropped, so casting j down to c_kw first is harmless
  assign w_shamt   = 32'(RADIX_W) * 32'(w_stage_nxt);
  assign w_k       = c_kw'(w_j_nxt) << w_shamt;
  assign w_run_nxt = (w_state_nxt == S_RUN);

  // Output registers driven from next-state values so the first address
  // appears one cycle after start; a held cycle recomputes identical values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_rom_cen   <= 1'b1;
      r_ma        <= '0;
      r_ma_valid  <= 1'b0;
      r_stage_idx <= '0;
      r_done      <= 1'b0;
    end else begin
      r_busy      <= w_run_nxt;
      r_rom_cen   <= !w_run_nxt;
      r_ma        <= w_run_nxt ? w_k : '0;
      r_ma_valid  <= w_run_nxt && (w_slot_nxt == 2'd0);
      r_stage_idx <= w_run_nxt ? w_stage_nxt : '0;
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign busy      = r_busy;
  assign ROM_CEN   = r_rom_cen;
  assign MA0       = r_ma[RADIX_W-1:0];
  assign MA1       = r_ma[2*RADIX_W-1:RADIX_W];
  assign MA2       = r_ma[3*RADIX_W-1:2*RADIX_W];
  assign ma_valid  = r_ma_valid;
  assign stage_idx = r_stage_idx;
  assign done      = r_done;

endmodule

`default_nettype wire
